// File: rtl/hd_encode_class_fetch.sv
// rtl/hd_encode_class_fetch.sv - HD projection MAC, byte-serial class memory and per-chunk class fetch
// Optional macro HD_ENC_SATURATE_EN: saturating accumulators instead of wrapping ones.
module hd_encode_class_fetch #(
    parameter int DHV_SIZE       = 4000,
    parameter int DIV_SIZE       = 512,
    parameter int N_SIZE         = 16,
    parameter int M_SIZE         = 16,
    parameter int FTWIDTH        = 8,
    parameter int DIM_WIDTH      = 16,
    parameter int CLASS_NUM      = 26,
    parameter int CLA_ADDR_WIDTH = 13
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          class_write,
    input  logic [FTWIDTH-1:0]            class_in,
    output logic                          class_write_done,
    input  logic                          feat_valid,
    input  logic [N_SIZE+M_SIZE-1:0]      projections,
    input  logic [N_SIZE*FTWIDTH-1:0]     features,
    output logic [M_SIZE*DIM_WIDTH-1:0]   encoding_out,
    output logic                          enc_done,
    output logic [CLA_ADDR_WIDTH-1:0]     class_addr,
    output logic [M_SIZE*FTWIDTH-1:0]     class_out,
    output logic                          class_valid,
    output logic [4:0]                    class_id,
    output logic [7:0]                    chunk_idx,
    output logic                          all_done
);
    localparam int ITER      = DIV_SIZE / N_SIZE;
    localparam int CHUNKS    = DHV_SIZE / M_SIZE;
    localparam int ROWS      = CLASS_NUM * CHUNKS;
    localparam int MEM_BYTES = ROWS * M_SIZE;
    localparam int LANE_W    = $clog2(M_SIZE);
    localparam int PW        = CLA_ADDR_WIDTH + LANE_W;
    localparam int IW        = $clog2(ITER);
    // Wide enough for an accumulator plus one full cycle of worst-case features.
    localparam int SW        = DIM_WIDTH + FTWIDTH + $clog2(N_SIZE) + 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DIM_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DIM_WIDTH - 1)));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [M_SIZE-1:0][FTWIDTH-1:0] mem [0:ROWS-1];
    logic [PW-1:0]                  wr_ptr;
    logic                           wr_en;

    assign wr_en = class_write && !class_write_done && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            class_write_done <= 1'b0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == PW'(MEM_BYTES - 1))
                class_write_done <= 1'b1;
        end
    end

    // Memory contents survive reset; only the pointer restarts.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[PW-1:LANE_W]][wr_ptr[LANE_W-1:0]] <= class_in;
    end

    logic signed [DIM_WIDTH-1:0] acc [M_SIZE];
    logic signed [DIM_WIDTH-1:0] nxt [M_SIZE];
    logic signed [SW-1:0]        tot [M_SIZE];
    logic [IW-1:0]               iter_cnt;
    logic                        clear_acc;

    always_comb begin
        for (int m = 0; m < M_SIZE; m++) begin
            tot[m] = clear_acc ? '0 : SW'(acc[m]);
            for (int n = 0; n < N_SIZE; n++) begin
                if (projections[m] ^ projections[M_SIZE+n])
                    tot[m] = tot[m] - SW'($signed({1'b0, features[n*FTWIDTH +: FTWIDTH]}));
                else
                    tot[m] = tot[m] + SW'($signed({1'b0, features[n*FTWIDTH +: FTWIDTH]}));
            end
            nxt[m] = tot[m][DIM_WIDTH-1:0];
`ifdef HD_ENC_SATURATE_EN
            if (tot[m] > SAT_MAX)
                nxt[m] = {1'b0, {(DIM_WIDTH-1){1'b1}}};
            else if (tot[m] < SAT_MIN)
                nxt[m] = {1'b1, {(DIM_WIDTH-1){1'b0}}};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int m = 0; m < M_SIZE; m++) acc[m] <= '0;
            iter_cnt  <= '0;
            clear_acc <= 1'b0;
            enc_done  <= 1'b0;
        end else begin
            enc_done <= 1'b0;
            if (feat_valid) begin
                for (int m = 0; m < M_SIZE; m++) acc[m] <= nxt[m];
                clear_acc <= 1'b0;
                if (iter_cnt == IW'(ITER - 1)) begin
                    iter_cnt  <= '0;
                    enc_done  <= 1'b1;
                    clear_acc <= 1'b1;
                end else begin
                    iter_cnt <= iter_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < M_SIZE; g++) begin : g_out
        assign encoding_out[g*DIM_WIDTH +: DIM_WIDTH] = acc[g];
    end

    logic [1:0] state;
    logic [4:0] class_cnt;
    logic [7:0] chunk;
    logic       pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            class_cnt  <= '0;
            chunk      <= '0;
            pending    <= 1'b0;
            class_addr <= '0;
            all_done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if ((enc_done || pending) && class_write_done) begin
                        state      <= S_READ;
                        class_cnt  <= '0;
                        class_addr <= CLA_ADDR_WIDTH'(chunk);
                        // A fresh pulse landing on the same cycle as a pending one stays queued.
                        pending    <= pending && enc_done;
                    end
                end
                S_READ: begin
                    if (enc_done && class_write_done)
                        pending <= 1'b1;
                    if (class_cnt == 5'(CLASS_NUM - 1)) begin
                        class_cnt <= '0;
                        if (chunk == 8'(CHUNKS - 1)) begin
                            state    <= S_DONE;
                            all_done <= 1'b1;
                        end else begin
                            chunk <= chunk + 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        class_cnt  <= class_cnt + 1'b1;
                        class_addr <= class_addr + CLA_ADDR_WIDTH'(CHUNKS);
                    end
                end
                S_DONE: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            class_out   <= '0;
            class_valid <= 1'b0;
            class_id    <= '0;
            chunk_idx   <= '0;
        end else begin
            class_valid <= (state == S_READ) && class_write_done;
            if ((state == S_READ) && class_write_done) begin
                class_out <= mem[class_addr];
                class_id  <= class_cnt;
                chunk_idx <= chunk;
            end
        end
    end
endmodule

// File: tb/tb_hd_encode_class_fetch.sv
// tb/tb_hd_encode_class_fetch.sv - directed bench for hd_encode_class_fetch (reduced chunk count and feature length)
module tb_hd_encode_class_fetch;
    localparam int DHV    = 160;
    localparam int DIV    = 256;
    localparam int N      = 16;
    localparam int M      = 16;
    localparam int FT     = 8;
    localparam int DW     = 16;
    localparam int CN     = 26;
    localparam int AW     = 9;
    localparam int ITER   = DIV / N;
    localparam int CHUNKS = DHV / M;
    localparam int BYTES  = CN * CHUNKS * M;

    logic              clk = 1'b0;
    logic              reset;
    logic              class_write;
    logic [FT-1:0]     class_in;
    logic              class_write_done;
    logic              feat_valid;
    logic [N+M-1:0]    projections;
    logic [N*FT-1:0]   features;
    logic [M*DW-1:0]   encoding_out;
    logic              enc_done;
    logic [AW-1:0]     class_addr;
    logic [M*FT-1:0]   class_out;
    logic              class_valid;
    logic [4:0]        class_id;
    logic [7:0]        chunk_idx;
    logic              all_done;

    hd_encode_class_fetch #(
        .DHV_SIZE(DHV), .DIV_SIZE(DIV), .N_SIZE(N), .M_SIZE(M), .FTWIDTH(FT),
        .DIM_WIDTH(DW), .CLASS_NUM(CN), .CLA_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .class_write(class_write), .class_in(class_in),
        .class_write_done(class_write_done), .feat_valid(feat_valid),
        .projections(projections), .features(features), .encoding_out(encoding_out),
        .enc_done(enc_done), .class_addr(class_addr), .class_out(class_out),
        .class_valid(class_valid), .class_id(class_id), .chunk_idx(chunk_idx),
        .all_done(all_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int vc          = 0;
    int enc_pulses  = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic encode(input logic [N+M-1:0] proj, input logic [N*FT-1:0] feat);
        for (int i = 0; i < ITER; i++) begin
            feat_valid  = 1'b1;
            projections = proj;
            features    = feat;
            @(negedge clk);
        end
        feat_valid = 1'b0;
    endtask

    // Class-stream scoreboard: row r byte k was written with (r*16+k) mod 256.
    initial begin
        logic [AW-1:0]   last_addr;
        logic [M*FT-1:0] exp_out;
        int              r;
        last_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (enc_done) enc_pulses++;
                if (class_valid) begin
                    r = (vc % CN) * CHUNKS + vc / CN;
                    for (int k = 0; k < M; k++) exp_out[k*FT +: FT] = 8'((r * M + k) % 256);
                    chk("class_id", 256'(class_id), 256'(vc % CN));
                    chk("chunk_idx", 256'(chunk_idx), 256'(vc / CN));
                    chk("class_addr", 256'(last_addr), 256'(r));
                    chk("class_out", 256'(class_out), 256'(exp_out));
                    vc++;
                end
            end
            last_addr = class_addr;
        end
    end

    initial begin
        logic [N*FT-1:0] ones, maxf, ramp;
        int              p0;
        ones = '0;
        maxf = '0;
        ramp = '0;
        for (int n = 0; n < N; n++) begin
            ones[n*FT +: FT] = 8'd1;
            maxf[n*FT +: FT] = 8'hFF;
            ramp[n*FT +: FT] = 8'(n + 1);
        end
        reset       = 1'b1;
        class_write = 1'b0;
        class_in    = '0;
        feat_valid  = 1'b0;
        projections = '0;
        features    = '0;
        repeat (2) @(negedge clk);

        chk("rst_encoding_out", 256'(encoding_out), 256'(0));
        chk("rst_enc_done", 256'(enc_done), 256'(0));
        chk("rst_write_done", 256'(class_write_done), 256'(0));
        chk("rst_class_valid", 256'(class_valid), 256'(0));
        chk("rst_all_done", 256'(all_done), 256'(0));
        chk("rst_class_addr", 256'(class_addr), 256'(0));
        chk("rst_class_out", 256'(class_out), 256'(0));
        chk("rst_class_id", 256'(class_id), 256'(0));
        chk("rst_chunk_idx", 256'(chunk_idx), 256'(0));
        reset = 1'b0;
        @(negedge clk);

        p0 = enc_pulses;
        encode('0, ones);
        chk("pos_enc_done", 256'(enc_done), 256'(1));
        chk("pos_value", 256'(encoding_out), {16{16'h0100}});
        repeat (3) @(negedge clk);
        chk("pos_enc_done_fall", 256'(enc_done), 256'(0));
        chk("pos_pulse_count", 256'(enc_pulses - p0), 256'(1));
        chk("pos_hold", 256'(encoding_out), {16{16'h0100}});

        encode(32'h0000_0001, ones);
        chk("flip_value", 256'(encoding_out), {{15{16'h0100}}, 16'hFF00});

        encode('0, maxf);
`ifdef HD_ENC_SATURATE_EN
        chk("ovf_value", 256'(encoding_out), {16{16'h7FFF}});
`else
        chk("ovf_value", 256'(encoding_out), {16{16'hFF00}});
`endif

        encode(32'h0001_0001, ramp);
        chk("mixed_value", 256'(encoding_out), {{15{16'h0860}}, 16'hF7A0});

        repeat (5) @(negedge clk);
        chk("no_fetch_before_fill", 256'(vc), 256'(0));

        for (int i = 0; i < BYTES; i++) begin
            class_write = 1'b1;
            class_in    = 8'(i);
            if (i == BYTES - 1) chk("write_done_before_last", 256'(class_write_done), 256'(0));
            @(negedge clk);
        end
        chk("write_done_after_last", 256'(class_write_done), 256'(1));
        class_in = 8'h55;
        repeat (3) @(negedge clk);
        class_write = 1'b0;
        repeat (5) @(negedge clk);
        chk("stale_enc_done_ignored", 256'(vc), 256'(0));

        for (int j = 0; j < CHUNKS / 2; j++) begin
            encode('0, ones);
            if (j == 0) begin
                chk("lat_enc_done", 256'(enc_done), 256'(1));
                @(negedge clk);
                chk("lat_valid_early", 256'(class_valid), 256'(0));
                @(negedge clk);
                chk("lat_valid", 256'(class_valid), 256'(1));
            end
            encode('0, ones);
            repeat (70) @(negedge clk);
            chk("pair_valid_count", 256'(vc), 256'(2 * CN * (j + 1)));
        end
        chk("run_valid_total", 256'(vc), 256'(CN * CHUNKS));
        chk("run_all_done", 256'(all_done), 256'(1));
        chk("run_last_chunk", 256'(chunk_idx), 256'(CHUNKS - 1));

        encode('0, ones);
        repeat (40) @(negedge clk);
        chk("sticky_all_done", 256'(all_done), 256'(1));
        chk("no_fetch_after_done", 256'(vc), 256'(CN * CHUNKS));

        feat_valid  = 1'b1;
        features    = ones;
        projections = '0;
        repeat (5) @(negedge clk);
        reset       = 1'b1;
        class_write = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        class_write = 1'b0;
        feat_valid  = 1'b0;
        chk("midrst_encoding_out", 256'(encoding_out), 256'(0));
        chk("midrst_write_done", 256'(class_write_done), 256'(0));
        chk("midrst_all_done", 256'(all_done), 256'(0));
        chk("midrst_chunk_idx", 256'(chunk_idx), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hd_encode_class_fetch.md
# hd_encode_class_fetch

Encode-and-fetch stage of the hyperdimensional (HD) inference accelerator. It holds three functions:
- a bipolar-projection MAC that encodes a feature stream into M-dimension hypervector chunks;
- a byte-serial class hypervector memory;
- a controller that fetches every class's matching chunk after each encoded chunk.

Its outputs feed the downstream similarity checker.

## Interface
- DHV_SIZE, 4000: hypervector dimension.
- DIV_SIZE, 512: features per input vector.
- N_SIZE, 16: features consumed per cycle.
- M_SIZE, 16: hypervector dimensions per chunk.
- FTWIDTH, 8: feature and class element width.
- DIM_WIDTH, 16: accumulator width.
- CLASS_NUM, 26: number of classes.
- CLA_ADDR_WIDTH, 13: class memory row address width.

Ports:
- clk  in  1  sole clock; everything is rising-edge.
- reset  in  1  synchronous, active-high.
- class_write  in  1  write strobe for class_in.
- class_in  in  FTWIDTH  class byte to store.
- class_write_done  out  1  class memory full; sticky.
- feat_valid  in  1  projections/features valid this cycle.
- projections  in  N_SIZE+M_SIZE  bits [M-1:0] are per-dimension signs; bits [M+N-1:M] are per-feature signs.
- features  in  N_SIZE*FTWIDTH  unsigned features; feature n is at [8n+7:8n].
- encoding_out  out  M_SIZE*DIM_WIDTH  signed accumulators; dimension m is at [16m+15:16m].
- enc_done  out  1  one-cycle pulse: a chunk has finished encoding.
- class_addr  out  CLA_ADDR_WIDTH  current class row address.
- class_out  out  M_SIZE*FTWIDTH  class row read data.
- class_valid  out  1  class_out is valid.
- class_id  out  5  class index of class_out.
- chunk_idx  out  8  chunk index of class_out.
- all_done  out  1  all chunks fetched; sticky.

## Operation
- **Derived constants**
  - ITER = DIV_SIZE/N_SIZE = 32.
  - CHUNKS = DHV_SIZE/M_SIZE = 250.
  - ROWS = CLASS_NUM*CHUNKS = 6500.
  - Class memory bytes = ROWS*M_SIZE = 104000.
- **Class memory write**
  - Each class_write cycle stores class_in at byte pointer p, in row p/16, byte lane p%16, then increments p.
  - After byte 103999 is stored, class_write_done rises and stays high.
  - Further writes are ignored.
  - Class c, chunk k lives at row c*CHUNKS+k.
- **Class memory read**
  - Synchronous, one-cycle latency.
  - Byte lane k maps to class_out[8k+7:8k].
  - Reads are enabled only when class_write_done is high.
- **Encoding MAC**
  - On each feat_valid cycle, out[m] += Σn s(m,n)·features[n].
  - s(m,n) = −1 if projections[m] XOR projections[M_SIZE+n], else +1.
  - Features are zero-extended; arithmetic is two's complement, DIM_WIDTH bits, wrapping.
  - After the ITER-th valid cycle, enc_done pulses and encoding_out holds the result.
  - The next feat_valid clears the accumulators before it is added; that cycle is the first term of the new chunk.
- **Fetch controller FSM**, states IDLE, READ, DONE:
  - IDLE→READ when (enc_done or pending) and class_write_done.
  - READ issues CLASS_NUM addresses, one per cycle: c*CHUNKS + chunk, for c = 0..25.
  - After the last address: if chunk = CHUNKS−1, go to DONE; otherwise increment chunk and return to IDLE.
  - DONE holds all_done = 1 until reset.
  - An enc_done that arrives while in READ sets a one-deep pending flag; further enc_done pulses while pending is set are dropped.
  - An enc_done that arrives before class_write_done is ignored.

## Timing
- **Reset values:** all outputs 0; accumulators 0; byte pointer, chunk, pending and state (IDLE) cleared.
- **enc_done:** asserted the cycle after the 32nd feat_valid edge.
- **Address issue:** class_addr for class c is issued on the c-th READ cycle. class_out, class_valid, class_id and chunk_idx follow one cycle later. class_valid is high for exactly 26 consecutive cycles per chunk.
- **enc_done to first class_valid:** 2 cycles, when not busy.
- **Simultaneous class_write and reset:** reset wins.
- **Reset mid-operation:** aborts the in-flight read and MAC. Memory contents are kept, but the write pointer restarts at 0.

## Configuration
- HD_ENC_SATURATE_EN
  - Defined: accumulators saturate to [−32768, 32767].
  - Undefined: accumulators wrap modulo 2^16.

## Test plan
- **Reset:** hold reset 2 cycles → all outputs 0, state IDLE.
- **All-positive encode:** features all 1, projections 0, 32 valid cycles → every out[m] = 512 (0x0200); enc_done pulses once.
- **Sign flip:** projections[0]=1, rest 0, features 1 → out[0] = 0xFE00, out[1..15] = 0x0200.
- **Overflow:** features 255, projections 0, 32 cycles → 0xFE00 wrap, or 0x7FFF with HD_ENC_SATURATE_EN.
- **Class memory fill:** write 104000 bytes of value i%256 → class_write_done after the last write. Fetching chunk 0 then shows class_id 1 at class_addr 250, with class_out byte0 = 0xA0.
- **Full run:** 250 chunks with a back-to-back enc_done during READ → 6500 class_valid cycles, chunk_idx 0..249, all_done sticky after the last one.
